// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 capture front end.
// Holds the FSM state enum, default geometry and RGB565 field widths.
package ov7670_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_VBLANK,
        ST_ACTIVE
    } state_t;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;

    // The sensor sends the high byte first: {R[4:0],G[5:3]} then {G[2:0],B[4:0]}.
    function automatic logic [PIX_W-1:0] pack_pixel(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/ov7670_edge_det.sv
// One-flop edge detector used on the camera VSYNC and HREF pins.
// Ports: clk, resetn, din in; rise/fall are single-cycle pulses.
module ov7670_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_d <= 1'b0;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;
    assign fall = ~din & din_d;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte stream to RGB565 stream with frame lock and geometry checks.
// Ports: clk/resetn/enable, vsync/href/d camera in, tready in;
//        tdata/tvalid/tlast stream out, frame_done pulse, sticky errors.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             vsync,
    input  logic             href,
    input  logic [7:0]       d,
    input  logic             tready,
    output logic [PIX_W-1:0] tdata,
    output logic             tvalid,
    output logic             tlast,
    output logic             frame_done,
    output logic             line_err,
    output logic             frame_err,
    output logic             ovf_err
);

    localparam int PW = $clog2(H_PIXELS + 1);
    localparam int LW = $clog2(V_LINES + 1);

    localparam logic [PW-1:0] H_MAX  = PW'(H_PIXELS);
    localparam logic [PW-1:0] H_LAST = PW'(H_PIXELS - 1);
    localparam logic [LW-1:0] L_LAST = LW'(V_LINES - 1);

    state_t state, state_nxt;

    logic vsync_rise, vsync_fall;
    logic unused_href_rise, href_fall;

    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic          phase;
    logic [7:0]    hi_byte;

    logic clr, eol, fdone_nxt, cap, load;

    ov7670_edge_det u_vsync_edge (
        .clk    (clk),
        .resetn (resetn),
        .din    (vsync),
        .rise   (vsync_rise),
        .fall   (vsync_fall)
    );

    ov7670_edge_det u_href_edge (
        .clk    (clk),
        .resetn (resetn),
        .din    (href),
        .rise   (unused_href_rise),
        .fall   (href_fall)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        eol       = 1'b0;
        fdone_nxt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!enable)         state_nxt = ST_IDLE;
                else if (vsync_rise) state_nxt = ST_VBLANK;
            end
            ST_VBLANK: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (vsync_fall) begin
                    clr       = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // A new VSYNC mid-frame means we lost lock: resync.
                if (vsync_rise) begin
                    state_nxt = ST_VBLANK;
                end else if (href_fall) begin
                    eol = 1'b1;
                    if (line_cnt == L_LAST) begin
                        fdone_nxt = 1'b1;
                        state_nxt = enable ? ST_SYNC : ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cap  = (state == ST_ACTIVE) && href;
    assign load = cap && phase && (pix_cnt != H_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            tdata      <= '0;
            tvalid     <= 1'b0;
            tlast      <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            frame_done <= fdone_nxt;

            if (state == ST_ACTIVE && vsync_rise) begin
                frame_err <= 1'b1;
            end

            if (clr) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                phase    <= 1'b0;
            end else if (eol) begin
                if (pix_cnt != H_MAX || phase) line_err <= 1'b1;
                line_cnt <= line_cnt + 1'b1;
                pix_cnt  <= '0;
                phase    <= 1'b0;
            end else if (cap) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= d;
                end else if (pix_cnt == H_MAX) begin
                    line_err <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end

            // Single-entry buffer: the camera cannot stall, so a
            // pending pixel that is not taken gets overwritten.
            if (load) begin
                tdata  <= pack_pixel(hi_byte, d);
                tlast  <= (pix_cnt == H_LAST);
                tvalid <= 1'b1;
                if (tvalid && !tready) ovf_err <= 1'b1;
            end else if (tready) begin
                tvalid <= 1'b0;
            end
        end
    end

endmodule
